// File: rtl/drc_lookup.sv
// DRC SRAM read-side front end: one-set lookup, per-way tag compare, write snoop.
// Optional hit/miss statistics counters are enabled by defining DRC_LOOKUP_STATS_EN.
module drc_lookup #(
   parameter int N_WAY     = 4,
   parameter int TAG_SIZE  = 20,
   parameter int IDX_SIZE  = 4,
   parameter int WAY_WIDTH = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [TAG_SIZE-1:0]       req_tag,
   input  logic [IDX_SIZE-1:0]       req_index,
   output logic                      sram_rden,
   output logic [IDX_SIZE-1:0]       sram_raddr,
   input  logic [N_WAY-1:0]          sram_valid,
   input  logic [N_WAY*TAG_SIZE-1:0] sram_tag,
   input  logic [N_WAY*2-1:0]        sram_type,
   input  logic [N_WAY*32-1:0]       sram_syn,
   input  logic [N_WAY*15-1:0]       sram_cnt,
   input  logic                      wr_en,
   input  logic [IDX_SIZE-1:0]       wr_addr,
   input  logic [WAY_WIDTH-1:0]      wr_line,
   input  logic [TAG_SIZE-1:0]       wr_tag,
   input  logic [1:0]                wr_type,
   input  logic [31:0]               wr_syn,
   input  logic [14:0]               wr_cnt,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic                      rsp_hit,
   output logic [WAY_WIDTH-1:0]      rsp_hit_way,
   output logic                      rsp_multi_hit,
   output logic [TAG_SIZE-1:0]       rsp_tag,
   output logic [IDX_SIZE-1:0]       rsp_index,
   output logic [N_WAY-1:0]          rsp_valid_w,
   output logic [N_WAY*2-1:0]        rsp_type,
   output logic [N_WAY*32-1:0]       rsp_syn,
   output logic [N_WAY*15-1:0]       rsp_cnt
`ifdef DRC_LOOKUP_STATS_EN
   ,
   input  logic                      stat_clr,
   output logic [31:0]               stat_hit_cnt,
   output logic [31:0]               stat_miss_cnt
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_RESP} state_t;

   state_t                    r_state, w_state_nxt;
   logic [TAG_SIZE-1:0]       r_tag;
   logic [IDX_SIZE-1:0]       r_index;
   logic [N_WAY-1:0]          r_valid_w, w_valid_nxt;
   logic [N_WAY*TAG_SIZE-1:0] r_wtag, w_wtag_nxt;
   logic [N_WAY*2-1:0]        r_type, w_type_nxt;
   logic [N_WAY*32-1:0]       r_syn, w_syn_nxt;
   logic [N_WAY*15-1:0]       r_cnt, w_cnt_nxt;
   logic                      r_hit, w_hit;
   logic                      r_multi, w_multi;
   logic [WAY_WIDTH-1:0]      r_hit_way, w_hit_way;
   logic [N_WAY-1:0]          w_match;
   logic                      w_accept, w_snoop;

   assign sram_raddr = req_index;
   assign w_accept   = (r_state == S_IDLE) && req_valid;

   always_comb begin
      w_state_nxt = r_state;
      req_ready   = 1'b0;
      sram_rden   = 1'b0;
      case (r_state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               sram_rden   = 1'b1;
               w_state_nxt = S_READ;
            end
         end
         S_READ:  w_state_nxt = S_RESP;
         S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Line state for next cycle: fresh SRAM data in READ, held data in RESP,
   // with any same-index write laid on top so the response is never stale.
   always_comb begin
      w_snoop     = wr_en && (wr_addr == r_index) && (r_state != S_IDLE);
      w_valid_nxt = (r_state == S_READ) ? sram_valid : r_valid_w;
      w_wtag_nxt  = (r_state == S_READ) ? sram_tag   : r_wtag;
      w_type_nxt  = (r_state == S_READ) ? sram_type  : r_type;
      w_syn_nxt   = (r_state == S_READ) ? sram_syn   : r_syn;
      w_cnt_nxt   = (r_state == S_READ) ? sram_cnt   : r_cnt;
      for (int i = 0; i < N_WAY; i++) begin
         if (w_snoop && (wr_line == WAY_WIDTH'(i))) begin
            w_valid_nxt[i]                     = 1'b1;
            w_wtag_nxt[i*TAG_SIZE +: TAG_SIZE] = wr_tag;
            w_type_nxt[i*2 +: 2]               = wr_type;
            w_syn_nxt[i*32 +: 32]              = wr_syn;
            w_cnt_nxt[i*15 +: 15]              = wr_cnt;
         end
      end
      for (int i = 0; i < N_WAY; i++)
         w_match[i] = w_valid_nxt[i] && (w_wtag_nxt[i*TAG_SIZE +: TAG_SIZE] == r_tag);
      w_hit_way = '0;
      for (int i = N_WAY-1; i >= 0; i--)
         if (w_match[i]) w_hit_way = WAY_WIDTH'(i);
      w_hit   = |w_match;
      // Clearing the lowest set bit leaves something only if two or more matched.
      w_multi = |(w_match & (w_match - N_WAY'(1)));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_tag     <= '0;
         r_index   <= '0;
         r_valid_w <= '0;
         r_wtag    <= '0;
         r_type    <= '0;
         r_syn     <= '0;
         r_cnt     <= '0;
         r_hit     <= 1'b0;
         r_multi   <= 1'b0;
         r_hit_way <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_tag   <= req_tag;
            r_index <= req_index;
         end
         if (r_state != S_IDLE) begin
            r_valid_w <= w_valid_nxt;
            r_wtag    <= w_wtag_nxt;
            r_type    <= w_type_nxt;
            r_syn     <= w_syn_nxt;
            r_cnt     <= w_cnt_nxt;
            r_hit     <= w_hit;
            r_multi   <= w_multi;
            r_hit_way <= w_hit_way;
         end
      end
   end

   assign rsp_valid     = (r_state == S_RESP);
   assign rsp_hit       = r_hit;
   assign rsp_hit_way   = r_hit_way;
   assign rsp_multi_hit = r_multi;
   assign rsp_tag       = r_tag;
   assign rsp_index     = r_index;
   assign rsp_valid_w   = r_valid_w;
   assign rsp_type      = r_type;
   assign rsp_syn       = r_syn;
   assign rsp_cnt       = r_cnt;

`ifdef DRC_LOOKUP_STATS_EN
   logic [31:0] r_stat_hit, r_stat_miss;
   logic        w_fire;

   assign w_fire = rsp_valid && rsp_ready;

   always_ff @(posedge clk) begin
      if (rst || stat_clr) begin
         r_stat_hit  <= '0;
         r_stat_miss <= '0;
      end else if (w_fire) begin
         if (r_hit && (r_stat_hit != 32'hFFFF_FFFF))
            r_stat_hit <= r_stat_hit + 32'd1;
         else if (!r_hit && (r_stat_miss != 32'hFFFF_FFFF))
            r_stat_miss <= r_stat_miss + 32'd1;
      end
   end

   assign stat_hit_cnt  = r_stat_hit;
   assign stat_miss_cnt = r_stat_miss;
`endif

endmodule

// File: tb/tb_drc_lookup.sv
// Scoreboard bench for drc_lookup: an SRAM model feeds the DUT, expected responses are queued per lookup.
module tb_drc_lookup;
   localparam int N = 4, T = 20, I = 4, W = 2;

   logic           clk = 1'b0, rst = 1'b1;
   logic           req_valid = 0, req_ready, sram_rden, wr_en = 0, rsp_valid, rsp_ready = 0;
   logic [T-1:0]   req_tag = '0, wr_tag = '0, rsp_tag;
   logic [I-1:0]   req_index = '0, sram_raddr, wr_addr = '0, rsp_index;
   logic [N-1:0]   sram_valid, rsp_valid_w;
   logic [N*T-1:0] sram_tag;
   logic [N*2-1:0] sram_type, rsp_type;
   logic [N*32-1:0] sram_syn, rsp_syn;
   logic [N*15-1:0] sram_cnt, rsp_cnt;
   logic [W-1:0]   wr_line = '0, rsp_hit_way;
   logic [1:0]     wr_type = '0;
   logic [31:0]    wr_syn = '0;
   logic [14:0]    wr_cnt = '0;
   logic           rsp_hit, rsp_multi_hit;
`ifdef DRC_LOOKUP_STATS_EN
   logic           stat_clr = 0;
   logic [31:0]    stat_hit_cnt, stat_miss_cnt;
`endif

   drc_lookup #(.N_WAY(N), .TAG_SIZE(T), .IDX_SIZE(I), .WAY_WIDTH(W)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_tag(req_tag), .req_index(req_index), .sram_rden(sram_rden), .sram_raddr(sram_raddr),
      .sram_valid(sram_valid), .sram_tag(sram_tag), .sram_type(sram_type), .sram_syn(sram_syn),
      .sram_cnt(sram_cnt), .wr_en(wr_en), .wr_addr(wr_addr), .wr_line(wr_line), .wr_tag(wr_tag),
      .wr_type(wr_type), .wr_syn(wr_syn), .wr_cnt(wr_cnt), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_hit(rsp_hit), .rsp_hit_way(rsp_hit_way),
      .rsp_multi_hit(rsp_multi_hit), .rsp_tag(rsp_tag), .rsp_index(rsp_index),
      .rsp_valid_w(rsp_valid_w), .rsp_type(rsp_type), .rsp_syn(rsp_syn), .rsp_cnt(rsp_cnt)
`ifdef DRC_LOOKUP_STATS_EN
      , .stat_clr(stat_clr), .stat_hit_cnt(stat_hit_cnt), .stat_miss_cnt(stat_miss_cnt)
`endif
   );

   always #5 clk = ~clk;

   // SRAM contents; tasks write it before the clock edge, so reads see writes (write-first)
   logic [N-1:0]    m_valid [16];
   logic [N*T-1:0]  m_tag   [16];
   logic [N*2-1:0]  m_type  [16];
   logic [N*32-1:0] m_syn   [16];
   logic [N*15-1:0] m_cnt   [16];

   always @(posedge clk) begin
      if (sram_rden) begin
         sram_valid <= m_valid[sram_raddr];
         sram_tag   <= m_tag[sram_raddr];
         sram_type  <= m_type[sram_raddr];
         sram_syn   <= m_syn[sram_raddr];
         sram_cnt   <= m_cnt[sram_raddr];
      end
   end

   typedef struct packed {
      logic          hit;
      logic [W-1:0]  way;
      logic          multi;
      logic [T-1:0]  tag;
      logic [I-1:0]  idx;
      logic [N-1:0]  vw;
      logic [N*2-1:0]  typ;
      logic [N*32-1:0] syn;
      logic [N*15-1:0] cnt;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0, n_fail = 0;
   int   m_hits = 0, m_miss = 0;

   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic exp_t calc(input logic [I-1:0] idx, input logic [T-1:0] tg);
      exp_t e;
      int nm;
      logic [N-1:0] m;
      e = '0; nm = 0;
      e.tag = tg; e.idx = idx; e.vw = m_valid[idx];
      e.typ = m_type[idx]; e.syn = m_syn[idx]; e.cnt = m_cnt[idx];
      for (int w = 0; w < N; w++) m[w] = m_valid[idx][w] && (m_tag[idx][w*T +: T] == tg);
      for (int w = N-1; w >= 0; w--) if (m[w]) e.way = W'(w);
      for (int w = 0; w < N; w++) if (m[w]) nm++;
      e.hit = (nm > 0); e.multi = (nm > 1);
      return e;
   endfunction

   task automatic set_line(input logic [I-1:0] idx, input int w, input logic v, input logic [T-1:0] tg,
                           input logic [1:0] ty, input logic [31:0] sy, input logic [14:0] ct);
      m_valid[idx][w] = v;
      m_tag[idx][w*T +: T] = tg;
      m_type[idx][w*2 +: 2] = ty;
      m_syn[idx][w*32 +: 32] = sy;
      m_cnt[idx][w*15 +: 15] = ct;
   endtask

   // Called just after a negedge; drives the snooped write and updates the SRAM model.
   task automatic wr(input logic [I-1:0] idx, input int w, input logic [T-1:0] tg,
                     input logic [1:0] ty, input logic [31:0] sy, input logic [14:0] ct);
      wr_en = 1; wr_addr = idx; wr_line = W'(w); wr_tag = tg; wr_type = ty; wr_syn = sy; wr_cnt = ct;
      set_line(idx, w, 1'b1, tg, ty, sy, ct);
      @(posedge clk); #1 wr_en = 0;
   endtask

   task automatic issue(input logic [I-1:0] idx, input logic [T-1:0] tg);
      @(negedge clk);
      chk("req_ready", req_ready, 1);
      req_valid = 1; req_index = idx; req_tag = tg;
      #1;
      chk("sram_rden", sram_rden, 1);
      chk("sram_raddr", sram_raddr, idx);
      q.push_back(calc(idx, tg));
      @(posedge clk); #1 req_valid = 0;
   endtask

   task automatic get_rsp(input int exp_lat);
      exp_t e;
      int n;
      @(negedge clk); n = 1;
      while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
      if (!rsp_valid) begin
         chk("rsp_timeout", 0, 1);
      end else if (q.size() == 0) begin
         chk("sb_empty", 0, 1);
      end else begin
         if (exp_lat > 0) chk("latency", n, exp_lat);
         e = q.pop_front();
         chk("hit", rsp_hit, e.hit);
         chk("hit_way", rsp_hit_way, e.way);
         chk("multi", rsp_multi_hit, e.multi);
         chk("tag", rsp_tag, e.tag);
         chk("index", rsp_index, e.idx);
         chk("valid_w", rsp_valid_w, e.vw);
         chk("type", rsp_type, e.typ);
         chk("syn", rsp_syn, e.syn);
         chk("cnt", rsp_cnt, e.cnt);
         if (e.hit) m_hits++; else m_miss++;
         rsp_ready = 1;
         @(posedge clk); #1 rsp_ready = 0;
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [T-1:0] tg;
      logic [I-1:0] ix;
      for (int i = 0; i < 16; i++)
         for (int w = 0; w < N; w++)
            set_line(I'(i), w, 1'($urandom), T'($urandom), 2'($urandom), $urandom, 15'($urandom));

      repeat (3) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_req_ready", req_ready, 1);
      chk("rst_sram_rden", sram_rden, 0);
      chk("rst_hit", rsp_hit, 0);
      chk("rst_cnt", rsp_cnt, 0);

      // reset while in READ drops the lookup
      set_line(4'd14, 0, 1'b1, 20'h0BEEF, 2'd3, 32'h1234_5678, 15'd77);
      issue(4'd14, 20'h0BEEF);
      @(negedge clk);
      rst = 1;
      @(posedge clk); #1 rst = 0;
      void'(q.pop_back());
      m_hits = 0; m_miss = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("rstrd_rsp_valid", rsp_valid, 0);
      end
      chk("rstrd_hit", rsp_hit, 0);
      chk("rstrd_cnt", rsp_cnt, 0);
      chk("rstrd_syn", rsp_syn, 0);
      chk("rstrd_tag", rsp_tag, 0);
      chk("rstrd_req_ready", req_ready, 1);

      // single hit in way 2
      for (int w = 0; w < N; w++) set_line(4'd3, w, 1'b1, 20'h00100 + T'(w), 2'(w), 32'hA000_0000 + w, 15'(100 + w));
      set_line(4'd3, 2, 1'b1, 20'h12345, 2'd2, 32'hFEED_0002, 15'd1234);
      issue(4'd3, 20'h12345);
      get_rsp(2);

      // miss: nothing matches
      for (int w = 0; w < N; w++) set_line(4'd5, w, 1'(w & 1), 20'h22220 + T'(w), 2'(3 - w), 32'hB000_0000 + w, 15'(500 + w));
      issue(4'd5, 20'h0F0F0);
      get_rsp(2);

      // ways 1 and 3 match; way 2 has the tag but is invalid
      set_line(4'd9, 0, 1'b1, 20'h00001, 2'd0, 32'h1, 15'd1);
      set_line(4'd9, 1, 1'b1, 20'h55AA5, 2'd1, 32'h2, 15'd2);
      set_line(4'd9, 2, 1'b0, 20'h55AA5, 2'd2, 32'h3, 15'd3);
      set_line(4'd9, 3, 1'b1, 20'h55AA5, 2'd3, 32'h4, 15'd4);
      issue(4'd9, 20'h55AA5);
      get_rsp(2);

      // snoop in RESP: other index ignored, same index turns miss into hit
      for (int w = 0; w < N; w++) set_line(4'd7, w, 1'b1, 20'h11110 + T'(w), 2'd1, 32'hC000_0000 + w, 15'(w));
      issue(4'd7, 20'hABCDE);
      @(negedge clk); @(negedge clk);
      chk("snp_rsp_valid", rsp_valid, 1);
      chk("snp_pre_hit", rsp_hit, 0);
      wr(4'd8, 0, 20'hABCDE, 2'd1, 32'hDEAD_0008, 15'd5);
      @(negedge clk);
      chk("snp_other_hit", rsp_hit, 0);
      chk("snp_other_cnt", rsp_cnt, q[0].cnt);
      wr(4'd7, 0, 20'hABCDE, 2'd2, 32'hCAFE_0007, 15'd2048);
      @(negedge clk);
      chk("snp_held_valid", rsp_valid, 1);
      chk("snp_hit", rsp_hit, 1);
      chk("snp_way", rsp_hit_way, 0);
      chk("snp_cnt0", rsp_cnt[14:0], 15'd2048);
      void'(q.pop_back());
      q.push_back(calc(4'd7, 20'hABCDE));
      get_rsp(0);

      // snoop in READ overrides the SRAM data captured that cycle
      for (int w = 0; w < N; w++) set_line(4'd10, w, 1'b1, 20'h33330 + T'(w), 2'd0, 32'hD000_0000 + w, 15'(20 + w));
      issue(4'd10, 20'h77777);
      @(negedge clk);
      wr(4'd10, 3, 20'h77777, 2'd3, 32'h0BAD_F00D, 15'd999);
      void'(q.pop_back());
      q.push_back(calc(4'd10, 20'h77777));
      get_rsp(0);

      // write in the accept cycle: SRAM returns the new data
      for (int w = 0; w < N; w++) set_line(4'd11, w, 1'b1, 20'h44440 + T'(w), 2'd1, 32'hE000_0000 + w, 15'(40 + w));
      @(negedge clk);
      req_valid = 1; req_index = 4'd11; req_tag = 20'h66666;
      wr_en = 1; wr_addr = 4'd11; wr_line = 2'd1; wr_tag = 20'h66666; wr_type = 2'd2; wr_syn = 32'h5555_AAAA; wr_cnt = 15'd321;
      set_line(4'd11, 1, 1'b1, 20'h66666, 2'd2, 32'h5555_AAAA, 15'd321);
      q.push_back(calc(4'd11, 20'h66666));
      @(posedge clk); #1 req_valid = 0; wr_en = 0;
      get_rsp(2);

      // request held off while in RESP, accepted the cycle after the handshake
      set_line(4'd12, 0, 1'b1, 20'h0C0C0, 2'd1, 32'h12, 15'd12);
      set_line(4'd13, 2, 1'b1, 20'h0D0D0, 2'd2, 32'h13, 15'd13);
      issue(4'd12, 20'h0C0C0);
      @(negedge clk); @(negedge clk);
      req_valid = 1; req_index = 4'd13; req_tag = 20'h0D0D0;
      #1;
      chk("resp_req_ready", req_ready, 0);
      chk("resp_sram_rden", sram_rden, 0);
      get_rsp(0);
      @(negedge clk);
      chk("b2b_req_ready", req_ready, 1);
      chk("b2b_sram_rden", sram_rden, 1);
      q.push_back(calc(4'd13, 20'h0D0D0));
      @(posedge clk); #1 req_valid = 0;
      get_rsp(2);

      // random lookups, half of them aimed at a stored tag
      for (int k = 0; k < 6; k++) begin
         ix = I'($urandom_range(15));
         tg = ($urandom_range(1) == 1) ? m_tag[ix][$urandom_range(N-1)*T +: T] : T'($urandom);
         issue(ix, tg);
         get_rsp(2);
      end

`ifdef DRC_LOOKUP_STATS_EN
      @(negedge clk);
      chk("stat_hit", stat_hit_cnt, m_hits);
      chk("stat_miss", stat_miss_cnt, m_miss);
      stat_clr = 1;
      @(posedge clk); #1 stat_clr = 0;
      @(negedge clk);
      chk("stat_hit_clr", stat_hit_cnt, 0);
      chk("stat_miss_clr", stat_miss_cnt, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
